// File: rtl/operand_entry_fsm.sv
// Operand entry stage for the hex calculator: debounces the enter/clear keys and
// captures A, B and the operation from the shared switch bank over three presses.
module operand_entry_fsm #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_enter_n,
  input  logic       key_clear_n,
  input  logic [3:0] sw_val,
  input  logic [1:0] sw_op,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] s,
  output logic       operands_valid,
  output logic [1:0] entry_state
);

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    SHOW     = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int KEY_ENTER = 0;
  localparam int KEY_CLEAR = 1;

  logic [1:0]            keyRaw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            armed_q, armed_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            startup_q, startup_d;

  state_e     state_q, state_d;
  logic [3:0] opA_q, opA_d;
  logic [3:0] opB_q, opB_d;
  logic [1:0] op_q, op_d;
  logic       valid_q, valid_d;

  assign keyRaw = {key_clear_n, key_enter_n};

  // A key is only armed once it has been seen released after reset, so a key
  // held through reset cannot fire until it is released and pressed again.
  always_comb begin
    startup_d = (startup_q == 2'd3) ? startup_q : startup_q + 2'd1;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    pulse_d   = 2'b00;
    armed_d   = armed_q;
    for (int k = 0; k < 2; k++) begin
      if (startup_q == 2'd3 && deb_q[k] && sync2_q[k]) begin
        armed_d[k] = 1'b1;
      end
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k]   = sync2_q[k];
        cnt_d[k]   = '0;
        pulse_d[k] = armed_q[k] & ~sync2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_q     <= 2'b11;
      cnt_q     <= '0;
      armed_q   <= 2'b00;
      pulse_q   <= 2'b00;
      startup_q <= 2'd0;
    end else begin
      sync1_q   <= keyRaw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      pulse_q   <= pulse_d;
      startup_q <= startup_d;
    end
  end

  // Clear wins over a simultaneous enter; the enter pulse is dropped.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (pulse_q[KEY_CLEAR]) begin
      state_d = ENTER_A;
      opA_d   = 4'h0;
      opB_d   = 4'h0;
      op_d    = 2'b00;
      valid_d = 1'b0;
    end else if (pulse_q[KEY_ENTER]) begin
      case (state_q)
        ENTER_A: begin
          opA_d   = sw_val;
          state_d = ENTER_B;
        end
        ENTER_B: begin
          opB_d   = sw_val;
          state_d = ENTER_OP;
        end
        ENTER_OP: begin
          op_d    = sw_op;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        default: begin
          valid_d = 1'b0;
          state_d = ENTER_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      opA_q   <= 4'h0;
      opB_q   <= 4'h0;
      op_q    <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign A              = opA_q;
  assign B              = opB_q;
  assign s              = op_q;
  assign operands_valid = valid_q;
  assign entry_state    = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Bench for operand_entry_fsm: a per-cycle comparison against a behavioural
// model of key acceptance and the three-press capture sequence.
module tb_operand_entry_fsm;

  localparam int D    = 4;
  localparam int HIST = D + 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       keyEnterN = 1'b1;
  logic       keyClearN = 1'b1;
  logic [3:0] swVal     = 4'h0;
  logic [1:0] swOp      = 2'b00;
  logic [3:0] dutA, dutB;
  logic [1:0] dutS, dutState;
  logic       dutValid;

  int totalChecks  = 0;
  int passedChecks = 0;

  bit         hist[2][HIST];
  bit         level[2];
  bit         armed[2];
  bit         pulsePend[2];
  bit         pins[2];
  bit         allDiff, wasLevel;
  int         edgesSinceReset;
  int         mStage;
  logic [3:0] mA, mB;
  logic [1:0] mS;
  bit         mValid;

  always #5 clk = ~clk;

  operand_entry_fsm #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_enter_n   (keyEnterN),
    .key_clear_n   (keyClearN),
    .sw_val        (swVal),
    .sw_op         (swOp),
    .A             (dutA),
    .B             (dutB),
    .s             (dutS),
    .operands_valid(dutValid),
    .entry_state   (dutState)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    totalChecks++;
    if (actual === expected) passedChecks++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    totalChecks++;
    if (actual >= lo && actual <= hi) passedChecks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
  endtask

  function automatic logic [15:0] dutVec();
    return {3'b000, dutA, dutB, dutS, dutValid, dutState};
  endfunction

  function automatic logic [15:0] modelVec();
    logic [1:0] st;
    st = 2'(mStage);
    return {3'b000, mA, mB, mS, mValid, st};
  endfunction

  // Model: a key level is accepted once D consecutive samples, seen two clocks
  // late, all disagree with the current level; a fall becomes a press if the key
  // has been seen released since reset. Presses drive a four-step capture cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < HIST; j++) hist[k][j] = 1'b1;
        level[k]     = 1'b1;
        armed[k]     = 1'b0;
        pulsePend[k] = 1'b0;
      end
      edgesSinceReset = 0;
      mStage = 0;
      mA = 4'h0;
      mB = 4'h0;
      mS = 2'b00;
      mValid = 1'b0;
    end else begin
      if (pulsePend[1]) begin
        mStage = 0;
        mA = 4'h0;
        mB = 4'h0;
        mS = 2'b00;
        mValid = 1'b0;
      end else if (pulsePend[0]) begin
        case (mStage)
          0: mA = swVal;
          1: mB = swVal;
          2: begin mS = swOp; mValid = 1'b1; end
          default: mValid = 1'b0;
        endcase
        mStage = (mStage + 1) % 4;
      end
      pins[0] = keyEnterN;
      pins[1] = keyClearN;
      for (int k = 0; k < 2; k++) begin
        for (int j = HIST - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = pins[k];
        allDiff = 1'b1;
        for (int i = 0; i < D; i++) if (hist[k][i+2] == level[k]) allDiff = 1'b0;
        wasLevel = level[k];
        pulsePend[k] = allDiff && wasLevel && armed[k];
        if (allDiff) level[k] = ~level[k];
        if (edgesSinceReset >= 3 && wasLevel && hist[k][2]) armed[k] = 1'b1;
      end
      if (edgesSinceReset < 1000) edgesSinceReset++;
    end
  end

  always @(negedge clk) checkOutput("cycle", dutVec(), modelVec());

  task automatic applyStimulus(input logic enterN, input logic clearN, input int cycles);
    keyEnterN = enterN;
    keyClearN = clearN;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulseReset(input int cycles);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic press(input int holdCycles);
    applyStimulus(1'b0, 1'b1, holdCycles);
    applyStimulus(1'b1, 1'b1, 10);
  endtask

  int latency;
  logic [1:0] stateBefore;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 1'b1, 20);
    checkOutput("reset_A", 16'(dutA), 16'd0);
    checkOutput("reset_B", 16'(dutB), 16'd0);
    checkOutput("reset_s", 16'(dutS), 16'd0);
    checkOutput("reset_valid", 16'(dutValid), 16'd0);
    checkOutput("reset_state", 16'(dutState), 16'd0);

    swVal = 4'h9; press(10);
    swVal = 4'h3; press(10);
    swOp = 2'b01; press(10);
    checkOutput("full_A", 16'(dutA), 16'd9);
    checkOutput("full_B", 16'(dutB), 16'd3);
    checkOutput("full_s", 16'(dutS), 16'd1);
    checkOutput("full_valid", 16'(dutValid), 16'd1);
    checkOutput("full_state", 16'(dutState), 16'd3);
    swVal = 4'hF;
    swOp = 2'b11;
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("hold_A", 16'(dutA), 16'd9);
    checkOutput("hold_s", 16'(dutS), 16'd1);

    stateBefore = dutState;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 2);
      applyStimulus(1'b1, 1'b1, 2);
    end
    keyEnterN = 1'b0;
    latency = 0;
    while (dutState == stateBefore && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    checkRange("bounce_latency", latency, 5, 7);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("bounce_state", 16'(dutState), 16'd0);
    checkOutput("bounce_valid", 16'(dutValid), 16'd0);
    checkOutput("bounce_A_kept", 16'(dutA), 16'd9);
    applyStimulus(1'b1, 1'b1, 10);

    swVal = 4'h5;
    press(100);
    checkOutput("held_state", 16'(dutState), 16'd1);
    checkOutput("held_A", 16'(dutA), 16'd5);
    swVal = 4'h6;
    press(10);
    checkOutput("second_B", 16'(dutB), 16'd6);
    checkOutput("second_state", 16'(dutState), 16'd2);

    swOp = 2'b10;
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("clear_state", 16'(dutState), 16'd0);
    checkOutput("clear_A", 16'(dutA), 16'd0);
    checkOutput("clear_B", 16'(dutB), 16'd0);
    checkOutput("clear_s", 16'(dutS), 16'd0);
    checkOutput("clear_valid", 16'(dutValid), 16'd0);

    swVal = 4'h7;
    applyStimulus(1'b0, 1'b1, 2);
    pulseReset(2);
    applyStimulus(1'b0, 1'b1, 20);
    checkOutput("rst_held_state", 16'(dutState), 16'd0);
    checkOutput("rst_held_A", 16'(dutA), 16'd0);
    applyStimulus(1'b1, 1'b1, 15);
    press(10);
    checkOutput("rst_repress_A", 16'(dutA), 16'd7);
    checkOutput("rst_repress_state", 16'(dutState), 16'd1);

    for (int it = 0; it < 250; it++) begin
      int mode;
      swVal = 4'($urandom);
      swOp  = 2'($urandom);
      mode  = $urandom_range(0, 7);
      if (it % 60 == 59) pulseReset($urandom_range(1, 3));
      if (mode == 0)      applyStimulus(1'b0, 1'b0, $urandom_range(1, 12));
      else if (mode == 1) applyStimulus(1'b1, 1'b0, $urandom_range(1, 12));
      else                applyStimulus(1'b0, 1'b1, $urandom_range(1, 12));
      applyStimulus(1'b1, 1'b1, $urandom_range(1, 12));
    end
    applyStimulus(1'b1, 1'b1, 10);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/operand_entry_fsm.md
Name: operand_entry_fsm

Overview:
- Upstream input stage for the hex calculator.
- Debounces the board pushbuttons and captures operand A, operand B and the operation select in three sequential key presses from the shared switch bank.
- Presents registered A, B and s to the combinational calculator, with a valid flag and an entry-state code for the status LEDs.
- Lets the calculator use one 4-bit switch group instead of two, and holds inputs stable while switches move.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a key level change (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst_n  in  1  asynchronous active-low reset.
- key_enter_n  in  1  raw enter pushbutton, active-low, asynchronous, bouncy.
- key_clear_n  in  1  raw clear pushbutton, active-low, asynchronous, bouncy.
- sw_val  in  4  operand value switches.
- sw_op  in  2  operation switches: 00 add, 01 sub, 10 mul, 11 div.
- A  out  4  captured operand A, registered.
- B  out  4  captured operand B, registered.
- s  out  2  captured operation, registered.
- operands_valid  out  1  high while A, B and s form a complete, committed set.
- entry_state  out  2  current FSM state code, for the LEDs.

Behaviour:
- Reset (async assert, sync release):
  - A=0, B=0, s=00, operands_valid=0, entry_state=00.
  - Both debounced levels = 1 (released); debounce counters = 0; synchronizers = 1.
- Key conditioning, per key, independent:
  - 2-flop synchronizer.
  - Counter increments while the synced level differs from the debounced level; it clears to 0 whenever the two match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synced value and the counter clears.
  - Press pulse: exactly one clk cycle, on the debounced 1->0 transition.
  - Holding a key generates no further pulses. Bounce shorter than DEBOUNCE_CYCLES generates no pulse. Release generates no pulse.
- Latency:
  - A clean press is accepted DEBOUNCE_CYCLES+2 cycles after the pin falls (±1 cycle synchronizer uncertainty).
  - The press pulse is asserted in the cycle after acceptance.
  - Captured outputs and the state update on the clock edge that samples the pulse.
- FSM states (entry_state code):
  - ENTER_A (00): on enter pulse, A <= sw_val, go to ENTER_B.
  - ENTER_B (01): on enter pulse, B <= sw_val, go to ENTER_OP.
  - ENTER_OP (10): on enter pulse, s <= sw_op, operands_valid <= 1, go to SHOW.
  - SHOW (11): on enter pulse, operands_valid <= 0, go to ENTER_A. A, B and s keep their values.
  - With no pulse, the FSM holds its state and all outputs.
- Clear pulse, in any state:
  - Go to ENTER_A; A=0, B=0, s=00, operands_valid=0.
  - Clear has priority when clear and enter pulses occur in the same cycle; that enter pulse is discarded.
- Capture rules:
  - Switches are sampled only on the capture edge. Later switch movement has no effect on A, B or s.
  - A, B and s are never partially updated by one press.
- Value rules:
  - B=0 is accepted as-is; divide-by-zero reporting belongs downstream.
  - No arithmetic is performed in this block.
- Reset mid-operation: an async reset in any state, including mid-debounce, returns everything to reset values immediately. A key still held after reset release produces no pulse until it is released and pressed again.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES=4.)
- Reset check: after reset, hold both keys released for 20 cycles -> A=0, B=0, s=00, operands_valid=0, entry_state=00, no pulses.
- Full entry: sw_val=9 press; sw_val=3 press; sw_op=01 press (each press held 10 cycles, 10 cycles apart) -> A=9, B=3, s=01, operands_valid=1, entry_state=11. Change sw_val to F -> outputs unchanged.
- Bounce rejection: key_enter_n toggles every 2 cycles for 12 cycles, then settles low -> exactly one capture, occurring 4+2 cycles after settle (±1); entry_state advances by exactly one.
- Held key: key_enter_n held low for 100 cycles in ENTER_A -> single capture, entry_state=01; a second press is needed to capture B.
- Clear priority: in ENTER_OP, release both keys, then press both on the same edge -> entry_state=00, A=B=0, s=00, operands_valid=0.
- Async reset mid-debounce: assert rst_n low 2 cycles into an enter press, release reset with the key still held -> no capture; a release-then-press yields a capture into A.
